// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//
// Shared types for the SDRAM port arbiter:
//   - arbState_e : command sequencer states
//   - DEF_AW/DEF_DW : default address (16-bit words) and data widths
//   - wrEntry_t  : one write-FIFO entry, {addr, data}, at default widths.
//                  The FIFO stores entries in this same order (address in
//                  the upper bits), so a head entry splits as addr then data.

package sdram_arb_pkg;

    localparam int DEF_AW = 25;
    localparam int DEF_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT
    } arbState_e;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } wrEntry_t;

endpackage

// File: rtl/arb_wfifo.sv
// arb_wfifo
//
// Small synchronous FIFO that buffers download writes for the arbiter.
// A push into a full FIFO is accepted only when a pop happens in the
// same cycle, so a full FIFO stays full and loses nothing.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : push request and entry to store
//   pop_i         : remove the head entry (ignored when empty)
//   head_o        : current head entry
//   full_o        : registered, high when count == DEPTH
//   empty_o       : high when count == 0
//   count_o       : number of stored entries

module arb_wfifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             doPush;
    logic             doPop;

    assign doPop   = pop_i && (count_q != '0);
    assign doPush  = push_i && (!full_q || doPop);
    assign head_o  = mem_q[rdPtr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Occupancy after this cycle's push/pop; drives the registered full flag.
    always_comb begin
        count_d = count_q + CW'(doPush) - CW'(doPop);
    end

    // Storage array is not reset; nothing reads it while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//
// Shares one SDRAM controller port between the download writer and the
// tape-decoder reader. Writes are buffered in a FIFO; one command is in
// flight at a time and completes on m_ready or after TIMEOUT wait cycles.
// A pending read wins after STARVE_MAX consecutive write grants.
//
// Ports:
//   CLKSYS, RESETn       : clock, asynchronous active-low reset
//   w_req/w_addr/w_data  : write strobe and entry; w_full = FIFO full
//   r_req/r_addr         : read strobe and address; r_busy while in flight
//   r_data/r_valid       : read result and one-cycle completion strobe
//   m_addr/m_din         : controller address and write data
//   m_we/m_rd            : one-cycle controller command pulses
//   m_dout/m_ready       : controller read data and completion pulse
//   ovf                  : sticky, a write was dropped on a full FIFO
//   tmo                  : sticky, a command timed out

module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int WFIFO_DEPTH = 4,
    parameter int STARVE_MAX  = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic          CLKSYS,
    input  logic          RESETn,
    input  logic          w_req,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic          w_full,
    input  logic          r_req,
    input  logic [AW-1:0] r_addr,
    output logic          r_busy,
    output logic [DW-1:0] r_data,
    output logic          r_valid,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_din,
    output logic          m_we,
    output logic          m_rd,
    input  logic [DW-1:0] m_dout,
    input  logic          m_ready,
    output logic          ovf,
    output logic          tmo
);
    localparam int FCW = $clog2(WFIFO_DEPTH + 1);
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    arbState_e        state_q;
    arbState_e        state_d;
    logic             readPending_q;
    logic [AW-1:0]    readAddr_q;
    logic [SCW-1:0]   starveCnt_q;
    logic [TCW-1:0]   waitCnt_q;
    logic [DW-1:0]    rData_q;
    logic             rValid_q;
    logic             ovf_q;
    logic             tmo_q;

    logic [AW+DW-1:0] fifoHead;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             fifoPop;
    logic [FCW-1:0]   fifoCount;

    logic             waiting;
    logic             timeoutHit;
    logic             cmdDone;
    logic             readDone;
    logic             grantWrite;
    logic             grantRead;

    arb_wfifo #(
        .WIDTH (AW + DW),
        .DEPTH (WFIFO_DEPTH)
    ) wFifo (
        .clk_i   (CLKSYS),
        .rst_ni  (RESETn),
        .push_i  (w_req),
        .data_i  ({w_addr, w_data}),
        .pop_i   (fifoPop),
        .head_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // m_ready takes priority over a timeout landing in the same cycle.
    assign waiting    = (state_q == WR_WAIT) || (state_q == RD_WAIT);
    assign timeoutHit = waiting && !m_ready && (waitCnt_q == TCW'(TIMEOUT - 1));
    assign cmdDone    = waiting && (m_ready || timeoutHit);
    assign fifoPop    = cmdDone && (state_q == WR_WAIT);
    assign readDone   = cmdDone && (state_q == RD_WAIT);

    // Writes go first unless a read has already waited through STARVE_MAX grants.
    assign grantWrite = (state_q == IDLE) && !fifoEmpty &&
                        (!readPending_q || (starveCnt_q < SCW'(STARVE_MAX)));
    assign grantRead  = (state_q == IDLE) && !grantWrite && readPending_q;

    assign w_full  = fifoFull;
    assign r_busy  = readPending_q;
    assign r_data  = rData_q;
    assign r_valid = rValid_q;
    assign ovf     = ovf_q;
    assign tmo     = tmo_q;

    // State register.
    always_ff @(posedge CLKSYS or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: issue states last one cycle, wait states end on completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grantWrite) begin
                    state_d = WR_ISSUE;
                end else if (grantRead) begin
                    state_d = RD_ISSUE;
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            WR_WAIT:  if (cmdDone) state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  if (cmdDone) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Controller outputs; address and data stay stable for the whole command.
    always_comb begin
        m_we   = 1'b0;
        m_rd   = 1'b0;
        m_addr = '0;
        m_din  = '0;
        unique case (state_q)
            WR_ISSUE, WR_WAIT: begin
                m_we   = (state_q == WR_ISSUE);
                m_addr = fifoHead[AW+DW-1:DW];
                m_din  = fifoHead[DW-1:0];
            end
            RD_ISSUE, RD_WAIT: begin
                m_rd   = (state_q == RD_ISSUE);
                m_addr = readAddr_q;
            end
            default: begin
                m_we = 1'b0;
            end
        endcase
    end

    // Read latch, result return, starvation and wait counters, sticky flags.
    // A timed-out read still returns a strobe, with zero data.
    always_ff @(posedge CLKSYS or negedge RESETn) begin
        if (!RESETn) begin
            readPending_q <= 1'b0;
            readAddr_q    <= '0;
            rData_q       <= '0;
            rValid_q      <= 1'b0;
            starveCnt_q   <= '0;
            waitCnt_q     <= '0;
            ovf_q         <= 1'b0;
            tmo_q         <= 1'b0;
        end else begin
            if (r_req && !readPending_q) begin
                readPending_q <= 1'b1;
                readAddr_q    <= r_addr;
            end else if (readDone) begin
                readPending_q <= 1'b0;
            end

            rValid_q <= readDone;
            if (readDone) begin
                rData_q <= m_ready ? m_dout : '0;
            end

            if (!readPending_q || grantRead) begin
                starveCnt_q <= '0;
            end else if (grantWrite && (starveCnt_q != SCW'(STARVE_MAX))) begin
                starveCnt_q <= starveCnt_q + SCW'(1);
            end

            waitCnt_q <= waiting ? waitCnt_q + TCW'(1) : '0;

            if (timeoutHit) begin
                tmo_q <= 1'b1;
            end
            if (w_req && !fifoPop && (fifoCount == FCW'(WFIFO_DEPTH))) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//
// Directed bench for sdram_port_arbiter with a simple controller model that
// answers each command with m_ready after readyDelay cycles, or never when
// withhold is set. Inputs are driven and outputs sampled on the falling edge.

module tb_sdram_port_arbiter;

    logic        clock = 1'b0;
    logic        resetN;
    logic        wReq;
    logic [24:0] wAddr;
    logic [15:0] wData;
    logic        wFull;
    logic        rReq;
    logic [24:0] rAddr;
    logic        rBusy;
    logic [15:0] rData;
    logic        rValid;
    logic [24:0] mAddr;
    logic [15:0] mDin;
    logic        mWe;
    logic        mRd;
    logic [15:0] mDout;
    logic        mReady;
    logic        ovf;
    logic        tmo;

    int          checks = 0;
    int          errors = 0;

    int          readyDelay = 2;
    logic        withhold = 1'b0;
    logic [15:0] modelData = 16'h0000;
    int          lateReq = 0;
    int          lateAck = 0;

    logic [15:0] burstData [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    always #5 clock = ~clock;

    sdram_port_arbiter dut (
        .CLKSYS  (clock),
        .RESETn  (resetN),
        .w_req   (wReq),
        .w_addr  (wAddr),
        .w_data  (wData),
        .w_full  (wFull),
        .r_req   (rReq),
        .r_addr  (rAddr),
        .r_busy  (rBusy),
        .r_data  (rData),
        .r_valid (rValid),
        .m_addr  (mAddr),
        .m_din   (mDin),
        .m_we    (mWe),
        .m_rd    (mRd),
        .m_dout  (mDout),
        .m_ready (mReady),
        .ovf     (ovf),
        .tmo     (tmo)
    );

    // Controller model: a command seen in cycle C gets m_ready in cycle C+readyDelay.
    // A late-ready request from the main process fires an unsolicited pulse.
    initial begin
        int cd;
        cd     = 0;
        mReady = 1'b0;
        mDout  = 16'hA5A5;
        forever begin
            @(negedge clock);
            mReady = 1'b0;
            mDout  = 16'hA5A5;
            if (lateReq != lateAck) begin
                mReady  = 1'b1;
                mDout   = 16'hDEAD;
                lateAck = lateReq;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mReady = 1'b1;
                    mDout  = modelData;
                end
            end
            if ((mWe || mRd) && !withhold) begin
                cd = readyDelay;
            end
        end
    end

    // Watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic wr, input logic [24:0] wa, input logic [15:0] wd,
                                 input logic rd, input logic [24:0] ra);
        wReq  = wr;
        wAddr = wa;
        wData = wd;
        rReq  = rd;
        rAddr = ra;
    endtask

    task automatic waitForMrd(input string tag, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mRd) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic waitForValid(input string tag, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rValid) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        bit seen;
        int weSeen;
        int grants;
        int wIdx;
        bit prevBusy;
        bit rdSeen;
        bit rdDone;
        bit resumed;
        bit lateValid;

        resetN = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        repeat (3) tick();

        // Reset state
        checkOutput("rst_w_full",  32'(wFull),  32'd0);
        checkOutput("rst_r_busy",  32'(rBusy),  32'd0);
        checkOutput("rst_r_valid", 32'(rValid), 32'd0);
        checkOutput("rst_r_data",  32'(rData),  32'd0);
        checkOutput("rst_m_we",    32'(mWe),    32'd0);
        checkOutput("rst_m_rd",    32'(mRd),    32'd0);
        checkOutput("rst_m_addr",  32'(mAddr),  32'd0);
        checkOutput("rst_ovf",     32'(ovf),    32'd0);
        checkOutput("rst_tmo",     32'(tmo),    32'd0);
        resetN = 1'b1;
        tick();
        tick();

        // Single read: r_req at N, m_rd at N+2, data back 3 cycles after m_rd
        $display("[TB] single read");
        readyDelay = 3;
        modelData  = 16'hBEEF;
        applyStimulus(1'b0, '0, '0, 1'b1, 25'h000100);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        checkOutput("rd_busy_n1",  32'(rBusy), 32'd1);
        checkOutput("rd_mrd_n1",   32'(mRd),   32'd0);
        tick();
        checkOutput("rd_mrd_n2",   32'(mRd),   32'd1);
        checkOutput("rd_maddr",    32'(mAddr), 32'h100);
        checkOutput("rd_mwe_low",  32'(mWe),   32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) checkOutput("rd_mrd_once", 32'(mRd), 32'd0);
            if (k < 4) begin
                checkOutput("rd_wait_valid", 32'(rValid), 32'd0);
                checkOutput("rd_wait_busy",  32'(rBusy),  32'd1);
            end else begin
                checkOutput("rd_valid", 32'(rValid), 32'd1);
                checkOutput("rd_data",  32'(rData),  32'hBEEF);
                checkOutput("rd_busy_clr", 32'(rBusy), 32'd0);
            end
        end
        tick();
        checkOutput("rd_valid_pulse", 32'(rValid), 32'd0);

        // Write burst: four back-to-back writes, ready delay 2
        $display("[TB] write burst");
        readyDelay = 2;
        weSeen = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick();
            if (mWe) begin
                if (weSeen < 4) begin
                    checkOutput("burst_addr", 32'(mAddr), 32'(weSeen));
                    checkOutput("burst_data", 32'(mDin),  32'(burstData[weSeen]));
                end
                weSeen++;
            end
            if (k == 4) checkOutput("burst_full_set", 32'(wFull), 32'd1);
            if (k == 5) checkOutput("burst_full_clr", 32'(wFull), 32'd0);
            if (k < 4) applyStimulus(1'b1, 25'(k), burstData[k], 1'b0, '0);
            else       applyStimulus(1'b0, '0, '0, 1'b0, '0);
        end
        checkOutput("burst_count", 32'(weSeen), 32'd4);
        checkOutput("burst_ovf",   32'(ovf),    32'd0);

        // Starvation: FIFO kept topped up, one read issued mid-stream
        $display("[TB] starvation");
        modelData = 16'h5A5A;
        prevBusy  = 1'b0;
        grants    = 0;
        wIdx      = 0;
        rdSeen    = 1'b0;
        rdDone    = 1'b0;
        resumed   = 1'b0;
        for (int k = 0; k < 300 && !resumed; k++) begin
            tick();
            if (mWe && prevBusy && !rdSeen) grants++;
            if (mRd) begin
                rdSeen = 1'b1;
                checkOutput("starve_grants", 32'(grants), 32'd8);
                checkOutput("starve_maddr",  32'(mAddr),  32'h2A0);
            end
            if (rValid) begin
                rdDone = 1'b1;
                checkOutput("starve_rdata", 32'(rData), 32'h5A5A);
            end
            if (mWe && rdDone) resumed = 1'b1;
            prevBusy = rBusy;
            applyStimulus(!wFull, 25'(32'h1000 + wIdx), wIdx[15:0], (k == 8), 25'h2A0);
            if (!wFull) wIdx++;
        end
        checkOutput("starve_rd_seen", 32'(rdSeen),  32'd1);
        checkOutput("starve_resume",  32'(resumed), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        repeat (40) tick();
        checkOutput("starve_ovf", 32'(ovf), 32'd0);

        // Overflow: five writes with the controller silent
        $display("[TB] overflow");
        withhold = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            if (k == 4) begin
                checkOutput("ovf_full",   32'(wFull), 32'd1);
                checkOutput("ovf_before", 32'(ovf),   32'd0);
            end
            if (k == 5) checkOutput("ovf_set",    32'(ovf), 32'd1);
            if (k == 7) checkOutput("ovf_sticky", 32'(ovf), 32'd1);
            applyStimulus((k < 5), 25'(32'h300 + k), 16'(32'hC000 + k), 1'b0, '0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        resetN = 1'b0;
        #1;
        checkOutput("ovf_rst_ovf",  32'(ovf),   32'd0);
        checkOutput("ovf_rst_full", 32'(wFull), 32'd0);
        checkOutput("ovf_rst_mwe",  32'(mWe),   32'd0);
        tick();
        resetN   = 1'b1;
        withhold = 1'b0;
        tick();

        // Quick read so r_data holds a non-zero value before the timeout
        readyDelay = 1;
        modelData  = 16'h1234;
        applyStimulus(1'b0, '0, '0, 1'b1, 25'h0ABC);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        waitForMrd("pre_rd_issue", seen);
        waitForValid("pre_rd_valid", seen);
        checkOutput("pre_rd_data", 32'(rData), 32'h1234);

        // Timeout: read never answered
        $display("[TB] timeout");
        withhold = 1'b1;
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 25'h0DEF);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        waitForMrd("tmo_rd_issue", seen);
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 255) begin
                checkOutput("tmo_early",       32'(tmo),    32'd0);
                checkOutput("tmo_early_valid", 32'(rValid), 32'd0);
                checkOutput("tmo_busy",        32'(rBusy),  32'd1);
            end
        end
        checkOutput("tmo_set",      32'(tmo),    32'd1);
        checkOutput("tmo_rvalid",   32'(rValid), 32'd1);
        checkOutput("tmo_rdata",    32'(rData),  32'd0);
        checkOutput("tmo_busy_clr", 32'(rBusy),  32'd0);
        tick();
        checkOutput("tmo_sticky",   32'(tmo),    32'd1);
        checkOutput("tmo_vpulse",   32'(rValid), 32'd0);
        checkOutput("tmo_idle_rd",  32'(mRd),    32'd0);
        checkOutput("tmo_idle_we",  32'(mWe),    32'd0);

        // After a timeout the arbiter accepts and completes a normal read
        withhold   = 1'b0;
        readyDelay = 2;
        modelData  = 16'h7777;
        applyStimulus(1'b0, '0, '0, 1'b1, 25'h0123);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        waitForMrd("post_tmo_issue", seen);
        checkOutput("post_tmo_maddr", 32'(mAddr), 32'h123);
        waitForValid("post_tmo_valid", seen);
        checkOutput("post_tmo_data", 32'(rData), 32'h7777);

        // Async reset during RD_WAIT, then a late m_ready
        $display("[TB] reset mid read");
        withhold = 1'b1;
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 25'h0555);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        waitForMrd("rstrd_issue", seen);
        tick();
        tick();
        checkOutput("rstrd_busy_before", 32'(rBusy), 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("rstrd_busy",  32'(rBusy),  32'd0);
        checkOutput("rstrd_valid", 32'(rValid), 32'd0);
        checkOutput("rstrd_data",  32'(rData),  32'd0);
        checkOutput("rstrd_mrd",   32'(mRd),    32'd0);
        checkOutput("rstrd_maddr", 32'(mAddr),  32'd0);
        checkOutput("rstrd_tmo",   32'(tmo),    32'd0);
        tick();
        resetN   = 1'b1;
        withhold = 1'b0;
        tick();
        lateReq++;
        lateValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rValid) lateValid = 1'b1;
        end
        checkOutput("late_ready_valid", 32'(lateValid), 32'd0);
        checkOutput("late_ready_busy",  32'(rBusy),     32'd0);
        checkOutput("late_ready_mrd",   32'(mRd),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
